color_stabilizer: RTL and testbench

- Temporal hysteresis stage directly downstream of colorDetect_top, in the i_sysclk (125 MHz) domain.
- Takes the nine per-zone 3-bit color codes, sampled once per frame.
- Passes a zone's new color on to display_interface only after that color has been reported for HOLD_FRAMES consecutive frames. This suppresses flicker in the on-screen overlay.

---
 rtl/color_stabilizer_pkg.sv | 20 ++
 rtl/color_stabilizer_zone_hysteresis.sv | 76 +++++++
 rtl/color_stabilizer.sv | 69 ++++++
 tb/tb_color_stabilizer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/color_stabilizer_pkg.sv
// Shared color codes and default geometry for the color stabilizer.
package color_stabilizer_pkg;

    localparam int unsigned NUM_ZONES_DEF   = 9;
    localparam int unsigned COLOR_W_DEF     = 3;
    localparam int unsigned HOLD_FRAMES_DEF = 4;
    localparam int unsigned CNT_W_DEF       = 4;

    typedef enum logic [2:0] {
        COLOR_NONE   = 3'd0,
        COLOR_RED    = 3'd1,
        COLOR_GREEN  = 3'd2,
        COLOR_BLUE   = 3'd3,
        COLOR_YELLOW = 3'd4
    } color_e;

    // Codes at or above this value are not real colors and read as COLOR_NONE.
    localparam int unsigned COLOR_NUM_CODES = 5;

endpackage

// File: rtl/color_stabilizer_zone_hysteresis.sv
// Single-zone hysteresis: a new color is committed only after HOLD_FRAMES agreeing frames.
module zone_hysteresis #(
    parameter int unsigned COLOR_WIDTH = 3,
    parameter int unsigned CNT_WIDTH   = 4,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_frame,
    input  logic [COLOR_WIDTH-1:0] i_color,
    output logic [COLOR_WIDTH-1:0] o_committed,
    output logic                   o_changed
);

    localparam int unsigned CW1 = CNT_WIDTH + 1;

    logic [COLOR_WIDTH-1:0] committed_q, committed_d;
    logic [COLOR_WIDTH-1:0] cand_q, cand_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   changed_q, changed_d;
    logic                   hold_reached;

    assign hold_reached = (CW1'(cnt_q) + CW1'(1)) >= CW1'(HOLD_FRAMES);

    always_comb begin
        committed_d = committed_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        changed_d   = 1'b0;
        if (i_flush) begin
            cand_d = '0;
            cnt_d  = '0;
        end else if (i_frame) begin
            if (i_color == committed_q) begin
                cand_d = i_color;
                cnt_d  = '0;
            end else if (i_color == cand_q) begin
                if (hold_reached) begin
                    committed_d = i_color;
                    cnt_d       = '0;
                    changed_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end else begin
                cand_d = i_color;
                cnt_d  = CNT_WIDTH'(1);
                // A single agreeing frame is enough when the hold is one frame.
                if (HOLD_FRAMES == 1) begin
                    committed_d = i_color;
                    cnt_d       = '0;
                    changed_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            committed_q <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            changed_q   <= 1'b0;
        end else begin
            committed_q <= committed_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            changed_q   <= changed_d;
        end
    end

    assign o_committed = committed_q;
    assign o_changed   = changed_q;

endmodule

// File: rtl/color_stabilizer.sv
// Per-zone temporal hysteresis on detected colors, plus a frame counter gating o_valid.
module color_stabilizer
    import color_stabilizer_pkg::*;
#(
    parameter int unsigned NUM_ZONES   = NUM_ZONES_DEF,
    parameter int unsigned COLOR_WIDTH = COLOR_W_DEF,
    parameter int unsigned HOLD_FRAMES = HOLD_FRAMES_DEF,
    parameter int unsigned CNT_WIDTH   = CNT_W_DEF
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_flush,
    input  logic                             i_frame_done,
    input  logic [NUM_ZONES*COLOR_WIDTH-1:0] i_colors,
    output logic [NUM_ZONES*COLOR_WIDTH-1:0] o_colors,
    output logic [NUM_ZONES-1:0]             o_changed,
    output logic                             o_valid
);

    logic                 frame_acc;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                 valid_q, valid_d;

    // A flush in the same cycle discards the frame.
    assign frame_acc = i_frame_done & ~i_flush;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_acc && (frame_cnt_q < CNT_WIDTH'(HOLD_FRAMES))) begin
            frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
        end
        valid_d = valid_q | (frame_cnt_d == CNT_WIDTH'(HOLD_FRAMES));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_cnt_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            valid_q     <= valid_d;
        end
    end

    assign o_valid = valid_q;

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        logic [COLOR_WIDTH-1:0] raw;
        logic [COLOR_WIDTH-1:0] masked;

        assign raw    = i_colors[z*COLOR_WIDTH +: COLOR_WIDTH];
        assign masked = (raw >= COLOR_WIDTH'(COLOR_NUM_CODES)) ? COLOR_WIDTH'(COLOR_NONE) : raw;

        zone_hysteresis #(
            .COLOR_WIDTH (COLOR_WIDTH),
            .CNT_WIDTH   (CNT_WIDTH),
            .HOLD_FRAMES (HOLD_FRAMES)
        ) u_zone (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_flush     (i_flush),
            .i_frame     (frame_acc),
            .i_color     (masked),
            .o_committed (o_colors[z*COLOR_WIDTH +: COLOR_WIDTH]),
            .o_changed   (o_changed[z])
        );
    end

endmodule

// File: tb/tb_color_stabilizer.sv
// Directed, table-driven bench for color_stabilizer with HOLD_FRAMES = 4.
module tb_color_stabilizer;

    localparam logic [2:0] NONE   = 3'd0;
    localparam logic [2:0] RED    = 3'd1;
    localparam logic [2:0] GREEN  = 3'd2;
    localparam logic [2:0] BLUE   = 3'd3;
    localparam logic [2:0] YELLOW = 3'd4;
    localparam logic [2:0] BADC   = 3'd7;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        fd;
        logic [26:0] colors;
        logic [26:0] exp_colors;
        logic [8:0]  exp_chg;
        logic        exp_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        frame_done = 1'b0;
    logic [26:0] colors_in = '0;
    logic [26:0] colors_out;
    logic [8:0]  changed;
    logic        valid;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    color_stabilizer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_frame_done (frame_done),
        .i_colors     (colors_in),
        .o_colors     (colors_out),
        .o_changed    (changed),
        .o_valid      (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] fill(input logic [2:0] c);
        logic [26:0] r;
        for (int i = 0; i < 9; i++) r[i*3 +: 3] = c;
        return r;
    endfunction

    function automatic logic [26:0] put(input logic [26:0] b, input int z, input logic [2:0] c);
        logic [26:0] r;
        r = b;
        r[z*3 +: 3] = c;
        return r;
    endfunction

    task automatic add(input logic r, input logic f, input logic d, input logic [26:0] c,
                       input logic [26:0] ec, input logic [8:0] ech, input logic ev);
        vec_t v;
        v.rst = r; v.flush = f; v.fd = d; v.colors = c;
        v.exp_colors = ec; v.exp_chg = ech; v.exp_valid = ev;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic f, input logic d, input logic [26:0] c);
        rst = r; flush = f; frame_done = d; colors_in = c;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; frame_done = 1'b0;
    endtask

    task automatic check(input string name, input int idx, input logic [26:0] got, input logic [26:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %h expected %h", name, idx, got, exp);
        end
    endtask

    initial begin
        logic [26:0] s1, s2, s3, r9, g9, z1bad;
        int pulses;
        r9 = fill(RED);
        g9 = fill(GREEN);
        s1 = put(r9, 3, BLUE);
        s2 = put(s1, 0, GREEN);
        s3 = put(s2, 5, YELLOW);
        z1bad = put('0, 1, BADC);

        // reset, then four RED frames (one idle gap in between)
        add(1, 0, 0, '0, '0, 9'h000, 0);
        add(0, 0, 1, r9, '0, 9'h000, 0);
        add(0, 0, 0, r9, '0, 9'h000, 0);
        add(0, 0, 1, r9, '0, 9'h000, 0);
        add(0, 0, 1, r9, '0, 9'h000, 0);
        add(0, 0, 1, r9, r9, 9'h1FF, 1);
        add(0, 0, 0, r9, r9, 9'h000, 1);
        // zone3: BLUE BLUE RED BLUE BLUE BLUE BLUE
        add(0, 0, 1, put(r9, 3, BLUE), r9, 9'h000, 1);
        add(0, 0, 1, put(r9, 3, BLUE), r9, 9'h000, 1);
        add(0, 0, 1, r9,               r9, 9'h000, 1);
        add(0, 0, 1, put(r9, 3, BLUE), r9, 9'h000, 1);
        add(0, 0, 1, put(r9, 3, BLUE), r9, 9'h000, 1);
        add(0, 0, 1, put(r9, 3, BLUE), r9, 9'h000, 1);
        add(0, 0, 1, put(r9, 3, BLUE), s1, 9'h008, 1);
        add(0, 0, 0, s1, s1, 9'h000, 1);
        // zone0: three GREEN, flush, then four GREEN to commit
        add(0, 0, 1, put(s1, 0, GREEN), s1, 9'h000, 1);
        add(0, 0, 1, put(s1, 0, GREEN), s1, 9'h000, 1);
        add(0, 0, 1, put(s1, 0, GREEN), s1, 9'h000, 1);
        add(0, 1, 0, s1, s1, 9'h000, 1);
        add(0, 0, 1, put(s1, 0, GREEN), s1, 9'h000, 1);
        add(0, 0, 1, put(s1, 0, GREEN), s1, 9'h000, 1);
        add(0, 0, 1, put(s1, 0, GREEN), s1, 9'h000, 1);
        add(0, 0, 1, put(s1, 0, GREEN), s2, 9'h001, 1);
        add(0, 0, 0, s2, s2, 9'h000, 1);
        // zone5: flush+frame YELLOW discarded, so four more YELLOW are needed
        add(0, 1, 1, put(s2, 5, YELLOW), s2, 9'h000, 1);
        add(0, 0, 1, put(s2, 5, YELLOW), s2, 9'h000, 1);
        add(0, 0, 1, put(s2, 5, YELLOW), s2, 9'h000, 1);
        add(0, 0, 1, put(s2, 5, YELLOW), s2, 9'h000, 1);
        add(0, 0, 1, put(s2, 5, YELLOW), s3, 9'h020, 1);
        add(0, 0, 0, s3, s3, 9'h000, 1);
        // reset, then zone1 = code 7 for four frames: masked to NONE
        add(1, 0, 0, s3, '0, 9'h000, 0);
        add(0, 0, 1, z1bad, '0, 9'h000, 0);
        add(0, 0, 1, z1bad, '0, 9'h000, 0);
        add(0, 0, 1, z1bad, '0, 9'h000, 0);
        add(0, 0, 1, z1bad, '0, 9'h000, 1);
        add(0, 0, 0, z1bad, '0, 9'h000, 1);
        // two GREEN frames, reset, then a full new run (flush+frame holds frame count)
        add(0, 0, 1, g9, '0, 9'h000, 1);
        add(0, 0, 1, g9, '0, 9'h000, 1);
        add(1, 0, 0, g9, '0, 9'h000, 0);
        add(0, 0, 1, g9, '0, 9'h000, 0);
        add(0, 0, 1, g9, '0, 9'h000, 0);
        add(0, 0, 1, g9, '0, 9'h000, 0);
        add(0, 1, 1, g9, '0, 9'h000, 0);
        add(0, 0, 1, g9, '0, 9'h000, 1);
        add(0, 0, 1, g9, '0, 9'h000, 1);
        add(0, 0, 1, g9, '0, 9'h000, 1);
        add(0, 0, 1, g9, g9, 9'h1FF, 1);
        add(0, 0, 0, g9, g9, 9'h000, 1);
        // reset has priority over flush and frame
        add(1, 1, 1, r9, '0, 9'h000, 0);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].flush, vecs[i].fd, vecs[i].colors);
            check("colors", i, colors_out, vecs[i].exp_colors);
            check("changed", i, 27'(changed), 27'(vecs[i].exp_chg));
            check("valid", i, 27'(valid), 27'(vecs[i].exp_valid));
        end

        // back-to-back BLUE frames after reset: exactly one change pulse per zone
        step(1, 0, 0, '0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, (k < 6) ? 1'b1 : 1'b0, fill(BLUE));
            if (changed[4]) pulses++;
            if (k == 3) check("b2b_commit", k, colors_out, fill(BLUE));
            if (k == 3) check("b2b_chg", k, 27'(changed), 27'h1FF);
            if (k == 4) check("b2b_chg_drop", k, 27'(changed), 27'h0);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL b2b_pulses got %0d expected 1", pulses);
        end

        // HOLD-1 saturation: re-committed color with RED noise never commits early
        step(0, 0, 1, fill(RED));
        step(0, 0, 1, fill(RED));
        step(0, 0, 1, fill(RED));
        check("sat_hold", 0, colors_out, fill(BLUE));
        step(0, 0, 1, fill(RED));
        check("sat_commit", 0, colors_out, fill(RED));
        step(0, 0, 1, fill(RED));
        check("sat_stable", 0, 27'(changed), 27'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
